cmp_pipe_unit: RTL and testbench

- Streaming, parametrised successor to the single-cycle compare block in the ALU hierarchy.
- Takes operand pairs under a valid/ready handshake and evaluates one of eight compare/select functions in signed or unsigned mode through a two-stage pipeline.
- Outputs a registered result code plus a match bit, and optionally keeps a saturating match counter.
- Sits between the ALU operand register file and the ALU result mux; full backpressure is supported.

---
 rtl/cmp_pipe_unit.sv | 150 +++++++++++++++
 tb/tb_cmp_pipe_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_pipe_unit.sv
// Two-stage streaming compare/select unit with valid/ready handshake and stall-all backpressure.
// Define CMP_MATCH_CNT_EN to build the saturating match counter; otherwise MATCH_CNT is tied to 0.
module cmp_pipe_unit #(
  parameter int in_width  = 8,
  parameter int out_width = 16,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [in_width-1:0]  A,
  input  logic [in_width-1:0]  B,
  input  logic [2:0]           ALU_FUN,
  input  logic                 CMP_SIGNED,
  input  logic                 CMP_Enable,
  output logic                 CMP_Ready,
  input  logic                 OUT_Ready,
  output logic [out_width-1:0] CMP_OUT,
  output logic                 CMP_Flag,
  output logic                 CMP_Match,
  input  logic                 CNT_CLR,
  output logic [cnt_width-1:0] MATCH_CNT
);

  typedef enum logic [2:0] {
    FN_NOP = 3'd0,
    FN_EQ  = 3'd1,
    FN_GT  = 3'd2,
    FN_LT  = 3'd3,
    FN_GE  = 3'd4,
    FN_LE  = 3'd5,
    FN_NE  = 3'd6,
    FN_MAX = 3'd7
  } fun_e;

  typedef struct packed {
    logic [in_width-1:0] a;
    logic [in_width-1:0] b;
    fun_e                fun;
    logic                sgn;
  } req_t;

  // vld_q[0] is stage 1, vld_q[1] is stage 2 (drives CMP_Flag)
  logic [1:0]           vld_q, vld_d;
  req_t                 s1_q, s1_d;
  logic [out_width-1:0] out_q, out_d;
  logic                 match_q, match_d;

  logic stall, in_xfer, out_xfer;

  assign stall    = vld_q[1] & ~OUT_Ready;
  assign in_xfer  = CMP_Enable & ~stall;
  assign out_xfer = vld_q[1] & OUT_Ready;

  assign CMP_Ready = ~stall;
  assign CMP_Flag  = vld_q[1];
  assign CMP_OUT   = out_q;
  assign CMP_Match = match_q;

  // Compare datapath on stage-1 operands
  logic                 a_eq_b, a_gt_b;
  logic [in_width-1:0]  big;
  logic [out_width-1:0] big_ext;
  logic [out_width-1:0] res;
  logic                 hit;

  localparam logic [out_width-1:0] HI_MASK = ~out_width'({in_width{1'b1}});

  always_comb begin
    a_eq_b = (s1_q.a == s1_q.b);
    if (s1_q.sgn) a_gt_b = $signed(s1_q.a) > $signed(s1_q.b);
    else          a_gt_b = s1_q.a > s1_q.b;

    big     = a_gt_b ? s1_q.a : s1_q.b;
    big_ext = out_width'(big);
    if (s1_q.sgn && big[in_width-1]) big_ext = big_ext | HI_MASK;

    hit = 1'b0;
    case (s1_q.fun)
      FN_NOP: hit = 1'b0;
      FN_EQ:  hit = a_eq_b;
      FN_GT:  hit = a_gt_b;
      FN_LT:  hit = ~a_gt_b & ~a_eq_b;
      FN_GE:  hit = a_gt_b | a_eq_b;
      FN_LE:  hit = ~a_gt_b;
      FN_NE:  hit = ~a_eq_b;
      FN_MAX: hit = ~a_eq_b;
      default: hit = 1'b0;
    endcase

    if (s1_q.fun == FN_MAX) res = big_ext;
    else if (hit)           res = out_width'(s1_q.fun);
    else                    res = '0;
  end

  // Both stages hold (bubbles included) while the output is stalled
  always_comb begin
    vld_d   = vld_q;
    s1_d    = s1_q;
    out_d   = out_q;
    match_d = match_q;
    if (!stall) begin
      vld_d = {vld_q[0], in_xfer};
      if (in_xfer) begin
        s1_d.a   = A;
        s1_d.b   = B;
        s1_d.fun = fun_e'(ALU_FUN);
        s1_d.sgn = CMP_SIGNED;
      end
      out_d   = vld_q[0] ? res : '0;
      match_d = vld_q[0] & hit;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      vld_q   <= '0;
      s1_q    <= '0;
      out_q   <= '0;
      match_q <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      s1_q    <= s1_d;
      out_q   <= out_d;
      match_q <= match_d;
    end
  end

`ifdef CMP_MATCH_CNT_EN
  logic [cnt_width-1:0] cnt_q, cnt_d;

  // Clear wins over a same-cycle matching transfer; count sticks at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (CNT_CLR)                                 cnt_d = '0;
    else if (out_xfer && match_q && !(&cnt_q))   cnt_d = cnt_q + cnt_width'(1);
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign MATCH_CNT = cnt_q;
`else
  logic unused_cnt_inputs;
  assign unused_cnt_inputs = CNT_CLR ^ out_xfer;
  assign MATCH_CNT = '0;
`endif

endmodule

// File: tb/tb_cmp_pipe_unit.sv
// Directed self-checking bench for cmp_pipe_unit (in_width 8, out_width 16, cnt_width 2).
module tb_cmp_pipe_unit;
  localparam int IW = 8;
  localparam int OW = 16;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          RST;
  logic [IW-1:0] A, B;
  logic [2:0]    ALU_FUN;
  logic          CMP_SIGNED, CMP_Enable, OUT_Ready, CNT_CLR;
  logic          CMP_Ready, CMP_Flag, CMP_Match;
  logic [OW-1:0] CMP_OUT;
  logic [CW-1:0] MATCH_CNT;

  int n_total = 0;
  int n_pass  = 0;

  cmp_pipe_unit #(.in_width(IW), .out_width(OW), .cnt_width(CW)) dut (
    .clk(clk), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN), .CMP_SIGNED(CMP_SIGNED),
    .CMP_Enable(CMP_Enable), .CMP_Ready(CMP_Ready), .OUT_Ready(OUT_Ready),
    .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag), .CMP_Match(CMP_Match),
    .CNT_CLR(CNT_CLR), .MATCH_CNT(MATCH_CNT)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1; A = '0; B = '0; ALU_FUN = 3'd0; CMP_SIGNED = 1'b0;
    CMP_Enable = 1'b0; OUT_Ready = 1'b1; CNT_CLR = 1'b0;
    repeat (2) tick;
    RST = 1'b0;
    tick;
    n_total++; if (CMP_Ready !== 1'b1) $display("FAIL rst_ready got %b want 1", CMP_Ready); else n_pass++;
    n_total++; if (CMP_Flag !== 1'b0) $display("FAIL rst_flag got %b want 0", CMP_Flag); else n_pass++;
    n_total++; if (CMP_OUT !== 16'h0) $display("FAIL rst_out got %h want 0000", CMP_OUT); else n_pass++;
    n_total++; if (CMP_Match !== 1'b0) $display("FAIL rst_match got %b want 0", CMP_Match); else n_pass++;
    n_total++; if (MATCH_CNT !== 2'd0) $display("FAIL rst_cnt got %0d want 0", MATCH_CNT); else n_pass++;

    // two results in flight, held by a stall, then reset
    A = 8'd1; B = 8'd1; ALU_FUN = 3'd1; CMP_Enable = 1'b1; OUT_Ready = 1'b0;
    tick;
    A = 8'd2; ALU_FUN = 3'd2;
    tick;
    CMP_Enable = 1'b0;
    n_total++; if (CMP_Flag !== 1'b1) $display("FAIL inflight_flag got %b want 1", CMP_Flag); else n_pass++;
    n_total++; if (CMP_Ready !== 1'b0) $display("FAIL inflight_ready got %b want 0", CMP_Ready); else n_pass++;
    RST = 1'b1;
    #1;
    n_total++; if (CMP_Flag !== 1'b0) $display("FAIL async_rst_flag got %b want 0", CMP_Flag); else n_pass++;
    tick;
    RST = 1'b0; OUT_Ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      n_total++;
      if (CMP_Flag !== 1'b0 || CMP_OUT !== 16'h0 || CMP_Match !== 1'b0 || CMP_Ready !== 1'b1)
        $display("FAIL post_rst_quiet[%0d] got flag=%b out=%h match=%b ready=%b want 0 0000 0 1",
                 k, CMP_Flag, CMP_OUT, CMP_Match, CMP_Ready);
      else n_pass++;
    end
  endtask

  task automatic test_signed_unsigned;
    logic [7:0]  ta [8];
    logic [7:0]  tb [8];
    logic [2:0]  tf [8];
    logic        ts [8];
    logic [15:0] te [8];
    logic        tm [8];
    ta = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h01, 8'h80, 8'h80};
    tb = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h90, 8'h80, 8'h01, 8'h7F};
    tf = '{3'd2,  3'd2,  3'd7,  3'd7,  3'd7,  3'd3,  3'd3,  3'd4};
    ts = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
    te = '{16'h0002, 16'h0000, 16'h0001, 16'h0080, 16'hFF90, 16'h0003, 16'h0003, 16'h0000};
    tm = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0};
    OUT_Ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      A = ta[i]; B = tb[i]; ALU_FUN = tf[i]; CMP_SIGNED = ts[i]; CMP_Enable = 1'b1;
      tick;
      CMP_Enable = 1'b0;
      tick;
      n_total++;
      if (CMP_Flag !== 1'b1 || CMP_OUT !== te[i] || CMP_Match !== tm[i])
        $display("FAIL sgn_vec[%0d] got flag=%b out=%h match=%b want 1 %h %b",
                 i, CMP_Flag, CMP_OUT, CMP_Match, te[i], tm[i]);
      else n_pass++;
    end
    tick;
    n_total++; if (CMP_Flag !== 1'b0) $display("FAIL sgn_drain got %b want 0", CMP_Flag); else n_pass++;
  endtask

  task automatic test_functions;
    logic [15:0] te [8];
    logic        tm [8];
    te = '{16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0004, 16'h0005, 16'h0000, 16'h0055};
    tm = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    OUT_Ready = 1'b1; CMP_SIGNED = 1'b0;
    for (int i = 0; i < 8; i++) begin
      A = 8'h55; B = 8'h55; ALU_FUN = 3'(i); CMP_Enable = 1'b1;
      tick;
      CMP_Enable = 1'b0;
      tick;
      n_total++;
      if (CMP_Flag !== 1'b1 || CMP_OUT !== te[i] || CMP_Match !== tm[i])
        $display("FAIL fun_eq55[%0d] got flag=%b out=%h match=%b want 1 %h %b",
                 i, CMP_Flag, CMP_OUT, CMP_Match, te[i], tm[i]);
      else n_pass++;
    end
    tick;
    n_total++;
    if (CMP_OUT !== 16'h0 || CMP_Match !== 1'b0)
      $display("FAIL idle_zero got out=%h match=%b want 0000 0", CMP_OUT, CMP_Match);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    logic [7:0]  ta [5];
    logic [7:0]  tb [5];
    logic [2:0]  tf [5];
    logic [15:0] te [5];
    logic        tm [5];
    int in_i = 0, out_i = 0, stalls = 0;
    ta = '{8'd3, 8'd5, 8'd7, 8'h10, 8'd9};
    tb = '{8'd5, 8'd3, 8'd6, 8'h20, 8'd8};
    tf = '{3'd3, 3'd2, 3'd1, 3'd7,  3'd6};
    te = '{16'h0003, 16'h0002, 16'h0000, 16'h0020, 16'h0006};
    tm = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    CMP_SIGNED = 1'b0;
    for (int k = 0; k < 30; k++) begin
      OUT_Ready = !(k >= 3 && k <= 6);
      if (in_i < 5) begin
        A = ta[in_i]; B = tb[in_i]; ALU_FUN = tf[in_i]; CMP_Enable = 1'b1;
      end else CMP_Enable = 1'b0;
      #1;
      if (CMP_Flag) begin
        n_total++;
        if (out_i >= 5)
          $display("FAIL bp_extra got out=%h want no result", CMP_OUT);
        else if (CMP_OUT !== te[out_i] || CMP_Match !== tm[out_i])
          $display("FAIL bp_result[%0d] got out=%h match=%b want %h %b",
                   out_i, CMP_OUT, CMP_Match, te[out_i], tm[out_i]);
        else n_pass++;
        if (!OUT_Ready) begin
          stalls++;
          n_total++;
          if (CMP_Ready !== 1'b0) $display("FAIL bp_ready_k%0d got %b want 0", k, CMP_Ready);
          else n_pass++;
        end else out_i++;
      end
      if (CMP_Enable && CMP_Ready) in_i++;
      tick;
    end
    OUT_Ready = 1'b1;
    n_total++; if (out_i !== 5) $display("FAIL bp_count got %0d want 5", out_i); else n_pass++;
    n_total++; if (stalls !== 4) $display("FAIL bp_stall_cycles got %0d want 4", stalls); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] te [6];
    int in_i = 0, out_i = 0, xfer_k = -1;
    int flag_k [6];
    te = '{16'h0020, 16'h0020, 16'h0021, 16'h0031, 16'h0041, 16'h0051};
    OUT_Ready = 1'b1; CMP_SIGNED = 1'b0; ALU_FUN = 3'd7; B = 8'h20;
    for (int k = 0; k < 16; k++) begin
      if (in_i < 6) begin A = 8'(in_i * 16 + 1); CMP_Enable = 1'b1; end
      else CMP_Enable = 1'b0;
      #1;
      if (CMP_Flag && out_i < 6) begin
        n_total++;
        if (CMP_OUT !== te[out_i]) $display("FAIL b2b_out[%0d] got %h want %h", out_i, CMP_OUT, te[out_i]);
        else n_pass++;
        flag_k[out_i] = k;
        out_i++;
      end
      if (CMP_Enable && CMP_Ready) begin
        if (in_i == 0) xfer_k = k;
        in_i++;
      end
      tick;
    end
    CMP_Enable = 1'b0;
    n_total++; if (out_i !== 6) $display("FAIL b2b_count got %0d want 6", out_i); else n_pass++;
    n_total++;
    if (flag_k[0] !== xfer_k + 2) $display("FAIL b2b_latency got %0d want %0d", flag_k[0], xfer_k + 2);
    else n_pass++;
    for (int i = 1; i < 6; i++) begin
      n_total++;
      if (flag_k[i] !== flag_k[i-1] + 1)
        $display("FAIL b2b_gap[%0d] got %0d want %0d", i, flag_k[i], flag_k[i-1] + 1);
      else n_pass++;
    end
  endtask

  task automatic test_counter;
    logic [1:0] te [7];
`ifdef CMP_MATCH_CNT_EN
    te = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd1};
`else
    te = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    OUT_Ready = 1'b1; CMP_Enable = 1'b0; CNT_CLR = 1'b1;
    tick;
    CNT_CLR = 1'b0;
    n_total++; if (MATCH_CNT !== 2'd0) $display("FAIL cnt_clear got %0d want 0", MATCH_CNT); else n_pass++;
    for (int i = 0; i < 7; i++) begin
      A = 8'd4; B = 8'd4; ALU_FUN = 3'd1; CMP_SIGNED = 1'b0; CMP_Enable = 1'b1;
      tick;
      CMP_Enable = 1'b0;
      tick;
      CNT_CLR = (i == 5);
      tick;
      CNT_CLR = 1'b0;
      n_total++;
      if (MATCH_CNT !== te[i]) $display("FAIL cnt_step[%0d] got %0d want %0d", i, MATCH_CNT, te[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_signed_unsigned;
    test_functions;
    test_backpressure;
    test_back_to_back;
    test_counter;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
